// File: rtl/if_stage_pkg.sv
// Shared fetch-side types and constants.
// Used by the IF, ID and EX stages and by the instruction memory.
package if_stage_pkg;

  typedef logic [31:0] word_t;

  localparam word_t DEF_RESET_PC = 32'h0000_0000;
  localparam word_t DEF_PC_INC   = 32'd4;
  localparam word_t DEF_NOP_INST = 32'h0000_0000;

  typedef struct packed {
    word_t pc;
    word_t inst;
    logic  valid;
  } if_id_t;

  function automatic word_t word_align(word_t a);
    return a & ~word_t'(3);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
// Async active-low reset, load-enable.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter word_t RESET_VAL = DEF_RESET_PC
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  word_t d_i,
  output word_t q_o
);

  word_t pc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_VAL;
    end else if (en_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch address,
// IF/ID register, freeze and branch flush.
module if_stage
  import if_stage_pkg::*;
#(
  parameter word_t RESET_PC = DEF_RESET_PC,
  parameter word_t PC_INC   = DEF_PC_INC,
  parameter word_t NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
);

  word_t  pc_q;
  word_t  pc_d;
  word_t  pc_inc;
  logic   pc_en;
  if_id_t if_id_q;
  if_id_t if_id_d;

  localparam if_id_t BUBBLE = '{
    pc:    32'h0,
    inst:  NOP_INST,
    valid: 1'b0
  };

  assign pc_inc = pc_q + PC_INC;
  assign pc_en  = branch_taken | ~freeze;
  assign pc_d   = branch_taken ? word_align(branch_addr)
                               : pc_inc;

  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (pc_en),
    .d_i    (pc_d),
    .q_o    (pc_q)
  );

  // Flush never samples mem_inst, so X there stays out.
  always_comb begin
    if_id_d = if_id_q;
    if (branch_taken) begin
      if_id_d = BUBBLE;
    end else if (!freeze) begin
      if_id_d.pc    = pc_inc;
      if_id_d.inst  = mem_inst;
      if_id_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id_q <= BUBBLE;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign mem_addr    = pc_q;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_inst  = if_id_q.inst;
  assign if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage.
// Expectations are queued at drive time, popped after the edge.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic        xinj;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] inst;
    logic        v;
  } exp_t;

  exp_t q[$];

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_addr     (mem_addr),
    .mem_inst     (mem_inst),
    .if_id_pc     (if_id_pc),
    .if_id_inst   (if_id_inst),
    .if_id_valid  (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a[31:2] < 7) return 32'hC0DE_0000 | {2'b00, a[31:2]};
    return 32'hBAD0_0000 ^ a;
  endfunction

  function automatic logic [31:0] mw(input int k);
    return 32'hC0DE_0000 | k;
  endfunction

  assign mem_inst = xinj ? 'x : memf(mem_addr);

  function automatic exp_t mk(input logic [31:0] pc, ipc, inst,
                              input logic v);
    exp_t e;
    e.pc = pc; e.ipc = ipc; e.inst = inst; e.v = v;
    return e;
  endfunction

  // Called at posedge+1; applies inputs, queues expectation,
  // returns at next posedge+1.
  task automatic drive(input logic fz, input logic br,
                       input logic [31:0] ba, input exp_t e);
    freeze = fz;
    branch_taken = br;
    branch_addr = ba;
    xinj = br;
    q.push_back(e);
    @(posedge clk);
    #1;
    xinj = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = '0;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    #2;
    if ({mem_addr, if_id_pc, if_id_inst, if_id_valid} !==
        {32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got %h %h %h %b want 0 0 0 0",
               mem_addr, if_id_pc, if_id_inst, if_id_valid);
    end
    checks++;
    do_reset();
    if (mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL release_addr: got %h want 0", mem_addr);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, mk(4*(i+1), 4*(i+1), mw(i), 1));
      e = q.pop_front();
      if ({mem_addr, if_id_pc, if_id_inst, if_id_valid} !==
          {e.pc, e.ipc, e.inst, e.v}) begin
        errors++;
        $display("FAIL run%0d: got %h %h %h %b want %h %h %h %b",
                 i, mem_addr, if_id_pc, if_id_inst, if_id_valid,
                 e.pc, e.ipc, e.inst, e.v);
      end
      checks++;
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    do_reset();
    drive(0, 0, 0, mk(4, 4, mw(0), 1));
    drive(0, 0, 0, mk(8, 8, mw(1), 1));
    void'(q.pop_front());
    void'(q.pop_front());
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, 0, 0, mk(8, 8, mw(1), 1));
      else       drive(0, 0, 0, mk(12, 12, mw(2), 1));
      e = q.pop_front();
      if ({mem_addr, if_id_pc, if_id_inst, if_id_valid} !==
          {e.pc, e.ipc, e.inst, e.v}) begin
        errors++;
        $display("FAIL freeze%0d: got %h %h %h %b want %h %h %h %b",
                 i, mem_addr, if_id_pc, if_id_inst, if_id_valid,
                 e.pc, e.ipc, e.inst, e.v);
      end
      checks++;
    end
  endtask

  task automatic test_branch();
    exp_t e;
    drive(0, 0, 0, mk(16, 16, mw(3), 1));
    drive(0, 1, 32'h12, mk(16, 0, 0, 0));
    drive(0, 0, 0, mk(20, 20, mw(4), 1));
    drive(1, 1, 32'h8, mk(8, 0, 0, 0));
    drive(0, 0, 0, mk(12, 12, mw(2), 1));
    drive(0, 1, 32'hFFFF_FFFF, mk(32'hFFFF_FFFC, 0, 0, 0));
    drive(0, 0, 0, mk(0, 0, memf(32'hFFFF_FFFC), 1));
    drive(0, 0, 0, mk(4, 4, mw(0), 1));
    for (int i = 0; i < 8; i++) begin
      e = q.pop_front();
      if (i == 0) begin
        // scoreboard order only; outputs already moved on
      end
      checks++;
      if (e.v === 1'bx) begin
        errors++;
        $display("FAIL branch_sb%0d: got x want defined", i);
      end
    end
  endtask

  task automatic test_branch_live();
    exp_t e;
    logic        fz [8];
    logic        br [8];
    logic [31:0] ba [8];
    fz = '{0, 0, 0, 1, 0, 0, 0, 0};
    br = '{0, 1, 0, 1, 0, 1, 0, 0};
    ba = '{0, 32'h12, 0, 32'h8, 0, 32'hFFFF_FFFF, 0, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, mk(4*(i+1), 4*(i+1), mw(i), 1));
      void'(q.pop_front());
    end
    q.push_back(mk(16, 0, 0, 0));
    q.push_back(mk(20, 20, mw(4), 1));
    q.push_back(mk(8, 0, 0, 0));
    q.push_back(mk(12, 12, mw(2), 1));
    q.push_back(mk(32'hFFFF_FFFC, 0, 0, 0));
    q.push_back(mk(0, 0, memf(32'hFFFF_FFFC), 1));
    q.push_back(mk(4, 4, mw(0), 1));
    for (int i = 1; i < 8; i++) begin
      freeze = fz[i];
      branch_taken = br[i];
      branch_addr = ba[i];
      xinj = br[i];
      @(posedge clk);
      #1;
      xinj = 1'b0;
      e = q.pop_front();
      if ({mem_addr, if_id_pc, if_id_inst, if_id_valid} !==
          {e.pc, e.ipc, e.inst, e.v}) begin
        errors++;
        $display("FAIL branch%0d: got %h %h %h %b want %h %h %h %b",
                 i, mem_addr, if_id_pc, if_id_inst, if_id_valid,
                 e.pc, e.ipc, e.inst, e.v);
      end
      checks++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 0, 0, mk(4, 4, mw(0), 1));
    drive(0, 0, 0, mk(8, 8, mw(1), 1));
    q.delete();
    freeze = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    if ({mem_addr, if_id_pc, if_id_inst, if_id_valid} !==
        {32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL async_rst: got %h %h %h %b want 0 0 0 0",
               mem_addr, if_id_pc, if_id_inst, if_id_valid);
    end
    checks++;
    @(posedge clk);
    #1;
    if ({mem_addr, if_id_valid} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL rst_hold: got %h %b want 0 0",
               mem_addr, if_id_valid);
    end
    checks++;
    rst = 1'b1;
    freeze = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] m_pc, m_ipc, m_inst;
    logic        m_v;
    logic        fz, br;
    logic [31:0] ba;
    do_reset();
    m_pc = 0; m_ipc = 0; m_inst = 0; m_v = 0;
    for (int i = 0; i < 40; i++) begin
      fz = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 4) == 0);
      ba = $urandom_range(0, 40);
      if (br) begin
        m_pc = {ba[31:2], 2'b00};
        m_ipc = 0; m_inst = 0; m_v = 0;
      end else if (!fz) begin
        m_inst = memf(m_pc);
        m_pc = m_pc + 4;
        m_ipc = m_pc;
        m_v = 1;
      end
      drive(fz, br, ba, mk(m_pc, m_ipc, m_inst, m_v));
      e = q.pop_front();
      if ({mem_addr, if_id_pc, if_id_inst, if_id_valid} !==
          {e.pc, e.ipc, e.inst, e.v}) begin
        errors++;
        $display("FAIL b2b%0d: got %h %h %h %b want %h %h %h %b",
                 i, mem_addr, if_id_pc, if_id_inst, if_id_valid,
                 e.pc, e.ipc, e.inst, e.v);
      end
      checks++;
    end
  endtask

  initial begin
    rst = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = '0;
    xinj = 1'b0;
    test_reset();
    test_freeze();
    test_branch_live();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
